// File: rtl/pwm_pkg.sv
// Shared PWM constants, tick-divider computation and FSM state encoding
// used by both the capture block and the PWM generator.
package pwm_pkg;

  localparam int unsigned PWM_FREQ = 60;

  function automatic int unsigned clk_div(input int unsigned clk_freq,
                                          input int unsigned clk_ticks);
    return clk_freq / (PWM_FREQ * clk_ticks);
  endfunction

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_tick.sv
// Free-running tick divider: counts 0..CLK_DIV inclusive and asserts tick
// while the count is 0, giving one tick every CLK_DIV+1 clocks.
module pwm_tick
  import pwm_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 25000000,
  parameter int unsigned CLK_TICKS = 65536
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CLK_DIV = clk_div(CLK_FREQ, CLK_TICKS);
  localparam int unsigned DW      = (CLK_DIV > 0) ? $clog2(CLK_DIV + 1) : 1;

  logic [DW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == DW'(CLK_DIV)) ? '0 : cnt_q + 1'b1;
    tick  = (cnt_q == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and rising-to-rising period of an asynchronous PWM input
// in divider ticks; publishes on each rising edge and flags loss of signal.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter  int unsigned CLK_FREQ  = 25000000,
  parameter  int unsigned CLK_TICKS = 65536,
  localparam int unsigned W         = $clog2(CLK_TICKS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in,
  output logic [W-1:0] duty,
  output logic [W:0]   period,
  output logic         valid,
  output logic         lost
);

  localparam logic [W-1:0] HI_MAX  = W'(CLK_TICKS - 1);
  localparam logic [W:0]   PER_MAX = (W + 1)'(2 * CLK_TICKS - 1);

  logic tick;

  pwm_tick #(
    .CLK_FREQ  (CLK_FREQ),
    .CLK_TICKS (CLK_TICKS)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // [0],[1] form the synchronizer; [2] is the previous synchronized value.
  logic [2:0]   sync_q, sync_d;
  pwm_state_e   state_q, state_d;
  logic [W-1:0] hi_q, hi_d;
  logic [W:0]   per_q, per_d;
  logic [W-1:0] duty_q, duty_d;
  logic [W:0]   period_q, period_d;
  logic         valid_q, valid_d;
  logic         lost_q, lost_d;

  logic         rise, fall;
  logic [W-1:0] hi_inc, hi_start;
  logic [W:0]   per_inc, per_start;

  always_comb begin
    sync_d    = {sync_q[1:0], in};
    rise      = sync_q[1] & ~sync_q[2];
    fall      = ~sync_q[1] & sync_q[2];
    hi_inc    = (tick && hi_q != HI_MAX) ? hi_q + 1'b1 : hi_q;
    per_inc   = (tick && per_q != PER_MAX) ? per_q + 1'b1 : per_q;
    // A tick coincident with an edge is credited to the phase that starts there.
    hi_start  = W'(tick);
    per_start = (W + 1)'(tick);

    state_d  = state_q;
    hi_d     = hi_q;
    per_d    = per_q;
    duty_d   = duty_q;
    period_d = period_q;
    valid_d  = 1'b0;
    lost_d   = lost_q;

    case (state_q)
      ST_IDLE: begin
        if (rise) begin
          state_d = ST_HIGH;
          hi_d    = hi_start;
          per_d   = per_start;
        end
      end
      ST_HIGH: begin
        if (per_q == PER_MAX) begin
          state_d  = ST_IDLE;
          lost_d   = 1'b1;
          duty_d   = '0;
          period_d = '0;
        end else if (fall) begin
          // hi_q is frozen from here on and serves as the latched high count.
          state_d = ST_LOW;
          per_d   = per_inc;
        end else begin
          hi_d  = hi_inc;
          per_d = per_inc;
        end
      end
      ST_LOW: begin
        if (per_q == PER_MAX) begin
          state_d  = ST_IDLE;
          lost_d   = 1'b1;
          duty_d   = '0;
          period_d = '0;
        end else if (rise) begin
          state_d  = ST_HIGH;
          duty_d   = hi_q;
          period_d = per_q;
          valid_d  = 1'b1;
          lost_d   = 1'b0;
          hi_d     = hi_start;
          per_d    = per_start;
        end else begin
          per_d = per_inc;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q   <= '0;
      state_q  <= ST_IDLE;
      hi_q     <= '0;
      per_q    <= '0;
      duty_q   <= '0;
      period_q <= '0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      hi_q     <= hi_d;
      per_q    <= per_d;
      duty_q   <= duty_d;
      period_q <= period_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  assign duty   = duty_q;
  assign period = period_q;
  assign valid  = valid_q;
  assign lost   = lost_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter CLK_FREQ, default 25000000, SHALL be the clk frequency in Hz.
REQ-002 Parameter CLK_TICKS, default 65536, SHALL be the ticks per nominal PWM period.
REQ-003 Local constant PWM_FREQ = 60 Hz; CLK_DIV = CLK_FREQ/(PWM_FREQ*CLK_TICKS); W = $clog2(CLK_TICKS).
REQ-004 clk  input  1  system clock at CLK_FREQ Hz.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in  input  1  asynchronous PWM signal to measure.
REQ-007 duty  output  W  high time of the last complete period, in ticks.
REQ-008 period  output  W+1  rising-to-rising time of the last complete period, in ticks.
REQ-009 valid  output  1  one-clk pulse when duty/period update.
REQ-010 lost  output  1  level; high when no valid PWM is being received.

Function
REQ-011 in SHALL pass through a 2-flop synchronizer; edges SHALL be detected on the synchronized value (3 clk input-to-edge latency).
REQ-012 The tick divider SHALL count 0..CLK_DIV inclusive, wrap to 0, and assert tick when it equals 0 (one tick per CLK_DIV+1 clks), free-running from reset.
REQ-013 FSM states: IDLE, HIGH, LOW; reset state IDLE.
REQ-014 IDLE: rising edge -> HIGH, clear counters; no publication; falling edge ignored.
REQ-015 HIGH: falling edge -> LOW, latch high count; rising edge cannot occur.
REQ-016 LOW: rising edge -> HIGH; same clk SHALL set duty=latched high count, period=period count, pulse valid, clear lost, restart counters.
REQ-017 High counter (W bits) SHALL count ticks in HIGH, saturating at CLK_TICKS-1.
REQ-018 Period counter (W+1 bits) SHALL count ticks in HIGH and LOW since the last rising edge, saturating at 2*CLK_TICKS-1.
REQ-019 On the edge clk, counters SHALL load 1 if tick is also asserted, else 0 (coincident tick belongs to the new phase).
REQ-020 Timeout: period counter reaching 2*CLK_TICKS-1 in HIGH or LOW -> IDLE, lost=1, duty=0, period=0, no valid pulse.
REQ-021 Pulses shorter than one tick SHALL be published with duty 0; no glitch filter beyond REQ-011.
REQ-022 duty/period SHALL hold between publications; valid SHALL never assert on two consecutive clks.
REQ-023 A signal produced by the team's PWM generator with duty D (same parameters) SHALL be reported as D+-1.

Reset
REQ-024 rst SHALL asynchronously force: synchronizer flops 0, divider 0, counters 0, state IDLE, duty 0, period 0, valid 0, lost 1.
REQ-025 After rst deasserts, the first publication SHALL require one rising edge, one falling edge, and a second rising edge.
REQ-026 rst mid-measurement SHALL discard the partial measurement with no valid pulse.

Structure
REQ-027 Package pwm_pkg SHALL hold PWM_FREQ, the CLK_DIV computation, and the FSM state encoding, shared with the generator.
REQ-028 The tick divider SHALL be sub-module pwm_tick (params CLK_FREQ, CLK_TICKS; outputs tick), reusable by the generator.
REQ-029 Synchronizer, edge detect, FSM and counters SHALL stay in pwm_capture.

Verification (CLK_FREQ=3840, CLK_TICKS=16 -> CLK_DIV=4, tick every 5 clks)
REQ-030 Reset, in held 0 for 1000 clks -> duty=0, period=0, valid never asserts, lost=1 once timed out and thereafter.
REQ-031 in high 50 clks / low 30 clks, repeated -> valid pulse each rising edge after the first, duty=10+-1, period=16+-1, lost=0.
REQ-032 in stuck high after two good periods -> after 32 ticks lost=1, duty=0, period=0, state IDLE; resumed waveform -> publication after one full period.
REQ-033 3-clk high glitch within a low phase -> duty 0 published, no X, FSM remains consistent.
REQ-034 rst pulsed mid-HIGH -> outputs at reset values immediately, no valid pulse until two new rising edges.
REQ-035 Loopback with the PWM generator, duty 0, 1, 8, 15 -> reported duty within +-1 of each; duty 0 -> timeout, lost=1.
